// File: rtl/pw_seq_ctrl.sv
// rtl/pw_seq_ctrl.sv - multi-character password lock sequencer with timed lockout
//
// Purpose:
//   Collects PW_LEN characters one button press at a time and compares each
//   one with a fixed password. A single verdict is issued after the last
//   character, so verdict timing does not depend on where the first wrong
//   character was. Failed verdicts decrement tries_left. When tries_left
//   reaches zero the lock stays in lockout for exactly LOCKOUT_CYCLES cycles.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   synchronous active-low reset
//   char_in     in   [PW_WIDTH] character presented with enter
//   enter       in   level button; accepted once per press in COLLECT
//   relock      in   returns an unlocked lock to locked
//   open        out  high while unlocked
//   wrong       out  high after a failed verdict until the next accepted char
//   lockout     out  high while locked out (and in ALARM)
//   tries_left  out  [$clog2(MAX_TRIES+1)] remaining attempts
//   alarm       out  redundancy fault latched (0 when FAULT_DETECT_EN is undefined)
//
// Optional feature macro: FAULT_DETECT_EN
//   This macro adds a complemented state register, an inverted duplicate
//   mismatch flag and a second comparator. Any disagreement sends the lock
//   to a sticky ALARM state.

module pw_seq_ctrl #(
  parameter int                           PW_WIDTH       = 8,
  parameter int                           PW_LEN         = 4,
  parameter logic [PW_WIDTH*PW_LEN-1:0]   PASSWORD       = 32'h48454C50,
  parameter int                           MAX_TRIES      = 3,
  parameter int                           LOCKOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [PW_WIDTH-1:0]              char_in,
  input  logic                             enter,
  input  logic                             relock,
  output logic                             open,
  output logic                             wrong,
  output logic                             lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             alarm
);

  localparam int IDX_W = $clog2(PW_LEN + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(PW_LEN);
  localparam logic [TRY_W-1:0] TRIES_INIT = TRY_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_COLLECT  = 3'd0,
    S_RELEASE  = 3'd1,
    S_VERDICT  = 3'd2,
    S_UNLOCKED = 3'd3,
`ifdef FAULT_DETECT_EN
    S_LOCKOUT  = 3'd4,
    S_ALARM    = 3'd5
`else
    S_LOCKOUT  = 3'd4
`endif
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_mismatch;
  logic [CNT_W-1:0]     r_cnt;
  logic [TRY_W-1:0]     r_tries;
  logic                 r_wrong;

  state_t               w_state_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_mis_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [TRY_W-1:0]     w_tries_nxt;
  logic                 w_wrong_nxt;
  logic [TRY_W-1:0]     w_tries_dec;

  logic [PW_WIDTH-1:0]  w_exp;
  logic                 w_char_ne;

  // Primary comparator: select the expected character by index.
  always_comb begin
    w_exp = '0;
    for (int k = 0; k < PW_LEN; k++) begin
      if (int'(r_idx) == k) begin
        w_exp = PASSWORD[(PW_LEN-1-k)*PW_WIDTH +: PW_WIDTH];
      end
    end
  end

  assign w_char_ne   = (char_in != w_exp);
  assign w_tries_dec = r_tries - 1'b1;

`ifdef FAULT_DETECT_EN
  logic [2:0]                  r_state_n;
  logic                        r_mismatch_n;
  logic                        w_mis_n_nxt;
  logic [PW_WIDTH*PW_LEN-1:0]  w_pw_shift;
  logic [PW_WIDTH-1:0]         w_exp2;
  logic                        w_char_ne2;
  logic                        w_fault;
  logic                        w_bad_enc;

  // Second comparator built differently: shift the password instead of
  // muxing it, then XOR-reduce instead of using !=.
  assign w_pw_shift = PASSWORD << (PW_WIDTH * int'(r_idx));
  assign w_exp2     = w_pw_shift[PW_WIDTH*PW_LEN-1 -: PW_WIDTH];
  assign w_char_ne2 = |(char_in ^ w_exp2);

  assign w_bad_enc = !(r_state inside {S_COLLECT, S_RELEASE, S_VERDICT,
                                       S_UNLOCKED, S_LOCKOUT, S_ALARM});
  assign w_fault   = (r_state_n != ~r_state) || (r_mismatch_n == r_mismatch);

  // The inverted duplicate follows its own update path from comparator 2.
  always_comb begin
    w_mis_n_nxt = r_mismatch_n;
    if ((r_state == S_COLLECT) && enter) begin
      w_mis_n_nxt = r_mismatch_n & ~w_char_ne2;
    end else if ((r_state == S_VERDICT) || w_bad_enc) begin
      w_mis_n_nxt = 1'b1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mis_nxt   = r_mismatch;
    w_cnt_nxt   = r_cnt;
    w_tries_nxt = r_tries;
    w_wrong_nxt = r_wrong;
    case (r_state)
      S_COLLECT: begin
        if (enter) begin
          w_mis_nxt   = r_mismatch | w_char_ne;
          w_idx_nxt   = r_idx + 1'b1;
          w_wrong_nxt = 1'b0;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!enter) begin
          w_state_nxt = (r_idx == IDX_LAST) ? S_VERDICT : S_COLLECT;
        end
      end
      S_VERDICT: begin
        w_idx_nxt = '0;
        w_mis_nxt = 1'b0;
        if (!r_mismatch) begin
          w_tries_nxt = TRIES_INIT;
          w_state_nxt = S_UNLOCKED;
        end else begin
          w_wrong_nxt = 1'b1;
          w_tries_nxt = w_tries_dec;
          w_cnt_nxt   = '0;
          w_state_nxt = (w_tries_dec == '0) ? S_LOCKOUT : S_COLLECT;
        end
      end
      S_UNLOCKED: begin
        // RELEASE waits for enter low, so a button held through relock is
        // never counted as a character.
        if (relock) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_RELEASE;
        end
      end
      S_LOCKOUT: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_tries_nxt = TRIES_INIT;
          w_wrong_nxt = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef FAULT_DETECT_EN
      S_ALARM: begin
        w_state_nxt = S_ALARM;
      end
`endif
      default: begin
        w_state_nxt = S_COLLECT;
        w_idx_nxt   = '0;
        w_mis_nxt   = 1'b0;
        w_cnt_nxt   = '0;
        w_tries_nxt = TRIES_INIT;
        w_wrong_nxt = 1'b0;
      end
    endcase
`ifdef FAULT_DETECT_EN
    if (w_fault) begin
      w_state_nxt = S_ALARM;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_cnt      <= '0;
      r_tries    <= TRIES_INIT;
      r_wrong    <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_mismatch <= w_mis_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tries    <= w_tries_nxt;
      r_wrong    <= w_wrong_nxt;
    end
  end

`ifdef FAULT_DETECT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state_n    <= ~S_COLLECT;
      r_mismatch_n <= 1'b1;
    end else begin
      r_state_n    <= ~w_state_nxt;
      r_mismatch_n <= w_mis_n_nxt;
    end
  end

  assign open    = (r_state == S_UNLOCKED);
  assign lockout = (r_state == S_LOCKOUT) || (r_state == S_ALARM);
  assign alarm   = (r_state == S_ALARM);
`else
  assign open    = (r_state == S_UNLOCKED);
  assign lockout = (r_state == S_LOCKOUT);
  assign alarm   = 1'b0;
`endif

  assign wrong      = r_wrong;
  assign tries_left = r_tries;

endmodule
